ram_burst_reader: RTL

Read-side initiator for the team's 16-bit dual-port RAM. On a start command it issues a burst of sequential reads on the RAM read port (`rd_en`/`rd_addr`/`rdata`, one-cycle registered read latency) and delivers the words on a valid/ready stream. A 2-entry output buffer absorbs the RAM latency, so the stream runs at one word per cycle under no backpressure. The RAM's write port is owned by a separate producer.

---
 rtl/ram_burst_reader.sv | 103 ++++++++++
 1 files changed

// File: rtl/ram_burst_reader.sv
// Burst read initiator for the 16-bit dual-port RAM: issues sequential reads and
// streams the returned words out through a 2-entry skid FIFO on a valid/ready port.
module ram_burst_reader #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [WIDTH-1:0]      ram_rdata_i,
  output logic                  m_valid_o,
  output logic [WIDTH-1:0]      m_data_o,
  input  logic                  m_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [LEN_WIDTH-1:0]  issue_rem_q, deliv_rem_q;
  logic                  vld_p1;
  logic [WIDTH-1:0]      fifo_p1 [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;
  logic                  pop, push, rd_en;
  logic [2:0]            occ;

  assign pop  = m_valid_o && m_ready_i;
  assign push = vld_p1;
  // Slots that will be occupied after this cycle, counting the read still in flight.
  assign occ   = {1'b0, cnt_q} + {2'b00, vld_p1} - {2'b00, pop};
  assign rd_en = (state_q == S_READ) && (issue_rem_q != '0) && (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (len_i == '0) ? S_DONE : S_READ;
      S_READ:  if ((issue_rem_q == '0) || ((issue_rem_q == LEN_WIDTH'(1)) && rd_en))
                 state_d = S_DRAIN;
      S_DRAIN: if (pop && (deliv_rem_q == LEN_WIDTH'(1))) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p0: read issue and burst bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_p0     <= '0;
      issue_rem_q <= '0;
      deliv_rem_q <= '0;
      vld_p1      <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= rd_en;
      if ((state_q == S_IDLE) && start_i) begin
        addr_p0     <= start_addr_i;
        issue_rem_q <= len_i;
        deliv_rem_q <= len_i;
      end else begin
        if (rd_en) begin
          addr_p0     <= addr_p0 + ADDR_WIDTH'(1);
          issue_rem_q <= issue_rem_q - LEN_WIDTH'(1);
        end
        if (pop) deliv_rem_q <= deliv_rem_q - LEN_WIDTH'(1);
      end
    end
  end

  // Stage p1: capture returned RAM word into the output FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_p1[0] <= '0;
      fifo_p1[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (push) begin
        fifo_p1[wr_ptr_q] <= ram_rdata_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign ram_rd_en_o   = rd_en;
  assign ram_rd_addr_o = addr_p0;
  assign m_valid_o     = (cnt_q != 2'd0);
  assign m_data_o      = fifo_p1[rd_ptr_q];

endmodule
